// File: rtl/instr_assembler_if.sv
// Request/response bundle for instr_assembler: the operand request channel
// and the assembled-word output stream.
interface instr_assembler_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  mnem;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_assembler.sv
// Assembles MIPS instruction words from mnemonic + operand fields and streams
// them, with byte addresses, through a small FIFO to the instruction loader.
module instr_assembler #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    instr_assembler_if.slave   bus,
    input  logic               flush,
    output logic               err,
    input  logic               err_clr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [4:0] {
        M_ADD  = 5'd0,  M_SUB  = 5'd1,  M_AND  = 5'd2,  M_OR   = 5'd3,
        M_SLT  = 5'd4,  M_SLTU = 5'd5,  M_ADDU = 5'd6,  M_SUBU = 5'd7,
        M_SLL  = 5'd8,  M_NOR  = 5'd9,  M_SRL  = 5'd10, M_SLLV = 5'd11,
        M_SRLV = 5'd12, M_JR   = 5'd13, M_JALR = 5'd14, M_ADDI = 5'd15,
        M_ORI  = 5'd16, M_LW   = 5'd17, M_SW   = 5'd18, M_BEQ  = 5'd19,
        M_LUI  = 5'd20, M_SLTI = 5'd21, M_BNE  = 5'd22, M_ANDI = 5'd23,
        M_J    = 5'd24, M_JAL  = 5'd25
    } mnem_e;

    logic [31:0]   word;
    logic          legal;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;
    logic          full, empty, accept, push, pop;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (bus.mnem)
            M_ADD:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100000};
            M_SUB:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100010};
            M_AND:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100100};
            M_OR:   word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100101};
            M_SLT:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b101010};
            M_SLTU: word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b101011};
            M_ADDU: word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100001};
            M_SUBU: word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100011};
            M_NOR:  word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100111};
            M_SLLV: word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b000100};
            M_SRLV: word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'b000110};
            // Only the immediate shifts carry shamt; they have no rs operand.
            M_SLL:  word = {6'h00, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000000};
            M_SRL:  word = {6'h00, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000010};
            M_JR:   word = {6'h00, bus.rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            M_JALR: word = {6'h00, bus.rs, 5'd0, bus.rd, 5'd0, 6'b001001};
            M_ADDI: word = {6'b001000, bus.rs, bus.rt, bus.imm};
            M_ORI:  word = {6'b001101, bus.rs, bus.rt, bus.imm};
            M_LW:   word = {6'b100011, bus.rs, bus.rt, bus.imm};
            M_SW:   word = {6'b101011, bus.rs, bus.rt, bus.imm};
            M_BEQ:  word = {6'b000100, bus.rs, bus.rt, bus.imm};
            M_LUI:  word = {6'b001111, 5'd0,   bus.rt, bus.imm};
            M_SLTI: word = {6'b001010, bus.rs, bus.rt, bus.imm};
            M_BNE:  word = {6'b000101, bus.rs, bus.rt, bus.imm};
            M_ANDI: word = {6'b001100, bus.rs, bus.rt, bus.imm};
            M_J:    word = {6'b000010, bus.target};
            M_JAL:  word = {6'b000011, bus.target};
            default: legal = 1'b0;
        endcase
    end

    assign full   = (count_q == (PW + 1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.in_valid & ~full;
    assign push   = accept & legal & ~flush;
    assign pop    = ~empty & bus.out_ready & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = BASE_ADDR;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = word;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // An illegal accept sets the flag even if a clear arrives in the same cycle.
        err_d = err_q;
        if (accept & ~legal)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_instr = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.out_addr  = addr_q;
    assign err           = err_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler: expected words are queued when a request
// is accepted and compared, with their addresses, as the FIFO drains.
module tb_instr_assembler;

    logic clk = 1'b0;
    logic rst, flush, err, err_clr;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = 32'h0;

    instr_assembler_if bus ();

    instr_assembler #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .flush(flush), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder: base opcode/funct per mnemonic, then field forcing.
    function automatic logic [31:0] model(input logic [4:0] m, input logic [4:0] r_s,
                                          input logic [4:0] r_t, input logic [4:0] r_d,
                                          input logic [4:0] sh, input logic [15:0] im,
                                          input logic [25:0] tg);
        logic [5:0] f, op;
        logic [4:0] s_rs, s_rt, s_rd, s_sh;
        s_rs = r_s; s_rt = r_t; s_rd = r_d; s_sh = 5'd0;
        f = 6'd0; op = 6'd0;
        if (m <= 5'd14) begin
            case (m)
                0: f = 6'h20;  1: f = 6'h22;  2: f = 6'h24;  3: f = 6'h25;
                4: f = 6'h2a;  5: f = 6'h2b;  6: f = 6'h21;  7: f = 6'h23;
                8: f = 6'h00;  9: f = 6'h27; 10: f = 6'h02; 11: f = 6'h04;
                12: f = 6'h06; 13: f = 6'h08; default: f = 6'h09;
            endcase
            if (m == 5'd8 || m == 5'd10) begin s_sh = sh; s_rs = 5'd0; end
            if (m == 5'd13) begin s_rt = 5'd0; s_rd = 5'd0; end
            if (m == 5'd14) s_rt = 5'd0;
            return {6'd0, s_rs, s_rt, s_rd, s_sh, f};
        end else if (m <= 5'd23) begin
            case (m)
                15: op = 6'h08; 16: op = 6'h0d; 17: op = 6'h23; 18: op = 6'h2b;
                19: op = 6'h04; 20: op = 6'h0f; 21: op = 6'h0a; 22: op = 6'h05;
                default: op = 6'h0c;
            endcase
            if (m == 5'd20) s_rs = 5'd0;
            return {op, s_rs, s_rt, im};
        end else begin
            return {(m == 5'd24) ? 6'h02 : 6'h03, tg};
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out: got instr %h addr %h, none expected",
                         bus.out_instr, bus.out_addr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_instr !== e) begin
                    n_fail++;
                    $display("FAIL out_instr: got %h expected %h", bus.out_instr, e);
                end
                n_checks++;
                if (bus.out_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL out_addr: got %h expected %h", bus.out_addr, exp_addr);
                end
            end
            exp_addr = exp_addr + 32'd4;
        end
    end

    // Entered at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [4:0] m, input logic [4:0] r_s, input logic [4:0] r_t,
                        input logic [4:0] r_d, input logic [4:0] sh,
                        input logic [15:0] im, input logic [25:0] tg);
        int t;
        bus.mnem = m; bus.rs = r_s; bus.rt = r_t; bus.rd = r_d;
        bus.shamt = sh; bus.imm = im; bus.target = tg;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready %b expected 1", bus.in_ready);
        end else if (m <= 5'd25) begin
            exp_q.push_back(model(m, r_s, r_t, r_d, sh, im, tg));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: pending %0d out_valid %b expected 0/0", exp_q.size(), bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; err_clr = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.mnem = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.shamt = '0; bus.imm = '0; bus.target = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.in_ready, err} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid/in_ready/err %b%b%b expected 010",
                     bus.out_valid, bus.in_ready, err);
        end
        n_checks++;
        if (bus.out_instr !== 32'h0 || bus.out_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: instr %h addr %h expected 0/0", bus.out_instr, bus.out_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        bus.out_ready = 1'b1;
        send(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: out_valid %b expected 1 one cycle after accept", bus.out_valid);
        end
        n_checks++;
        if (bus.out_instr !== 32'h2008_0005) begin
            n_fail++;
            $display("FAIL addi_word: got %h expected 20080005", bus.out_instr);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_forcing();
        send(5'd0, 5'd8, 5'd9, 5'd10, 5'd7, 16'h0, 26'd0);
        send(5'd8, 5'd5, 5'd1, 5'd2, 5'd4, 16'h0, 26'd0);
        send(5'd17, 5'd8, 5'd9, 5'd0, 5'd0, 16'h0004, 26'd0);
        send(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040);
        drain();
        n_checks++;
        if (model(5'd0, 5'd8, 5'd9, 5'd10, 5'd7, 16'h0, 26'd0) !== 32'h0109_5020 ||
            model(5'd8, 5'd5, 5'd1, 5'd2, 5'd4, 16'h0, 26'd0) !== 32'h0001_1100 ||
            model(5'd17, 5'd8, 5'd9, 5'd0, 5'd0, 16'h4, 26'd0) !== 32'h8D09_0004 ||
            model(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40) !== 32'h0800_0040) begin
            n_fail++;
            $display("FAIL model_ref: reference encoder disagrees with known words");
        end
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(5'd16, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(16'h100 + i), 26'd0);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ready: in_ready %b out_valid %b expected 0/1", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        fork
            send(5'd19, 5'd3, 5'd4, 5'd0, 5'd0, 16'hfffe, 26'd0);
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_err();
        bus.out_ready = 1'b1;
        send(5'd27, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal: err %b out_valid %b expected 1/0", err, bus.out_valid);
        end
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr: err %b expected 0", err);
        end
        err_clr = 1'b1;
        send(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0);
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_wins: err %b expected 1", err);
        end
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic test_mid_reset(input bit use_flush);
        bus.out_ready = 1'b1;
        send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(5'd23, 5'd7, 5'(i), 5'd0, 5'd0, 16'h00ff, 26'd0);
        if (use_flush) flush = 1'b1; else rst = 1'b1;
        exp_q.delete();
        exp_addr = 32'h0;
        if (use_flush) begin
            @(posedge clk); #1 flush = 1'b0;
        end else begin
            #1;
        end
        n_checks++;
        if ({bus.out_valid, bus.in_ready, err} !== {2'b01, use_flush}) begin
            n_fail++;
            $display("FAIL %s_state: out_valid/in_ready/err %b%b%b expected 01%b",
                     use_flush ? "flush" : "rst", bus.out_valid, bus.in_ready, err, use_flush);
        end
        n_checks++;
        if (bus.out_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_addr: got %h expected 00000000", use_flush ? "flush" : "rst", bus.out_addr);
        end
        if (!use_flush) begin
            @(posedge clk); #1 rst = 1'b0;
        end
        bus.out_ready = 1'b1;
        send(5'd20, 5'd9, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0);
        drain();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(5'($urandom_range(0, 25)), 5'($urandom), 5'($urandom), 5'($urandom),
                         5'($urandom), 16'($urandom), 26'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_forcing();
        test_full();
        test_err();
        test_mid_reset(1'b0);
        test_mid_reset(1'b1);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
Encoder counterpart to the CPU control decoder: accepts a mnemonic code plus operand fields and assembles the 32-bit MIPS instruction word that the decoder consumes. Assembled words are buffered in a small FIFO and streamed, with byte addresses, to the instruction-memory loader.
Used by the testbench/boot path to build programs for the single-cycle CPU, covering exactly the instruction subset the CPU decodes.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
BASE_ADDR, 32'h0000_0000, byte address of the first emitted word

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request carries an instruction
in_ready  output  1  request accepted this cycle when in_valid&in_ready
mnem  input  5  mnemonic code (table below)
rs  input  5  rs field
rt  input  5  rt field
rd  input  5  rd field
shamt  input  5  shift amount
imm  input  16  immediate / branch offset
target  input  26  jump target field
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head when out_valid&out_ready
out_instr  output  32  assembled word at FIFO head
out_addr  output  32  byte address of head word
flush  input  1  synchronous: empty FIFO, reset address to BASE_ADDR
err  output  1  sticky illegal-mnemonic flag
err_clr  input  1  synchronous clear of err

Behaviour:
- Mnemonic codes: 0 add,1 sub,2 and,3 or,4 slt,5 sltu,6 addu,7 subu,8 sll,9 nor,10 srl,11 sllv,12 srlv,13 jr,14 jalr,15 addi,16 ori,17 lw,18 sw,19 beq,20 lui,21 slti,22 bne,23 andi,24 j,25 jal; 26-31 illegal.
- R-type (op 000000), word = {op,rs,rt,rd,shamt,funct}. funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, sltu 101011, addu 100001, subu 100011, nor 100111, sll 000000, srl 000010, sllv 000100, srlv 000110, jr 001000, jalr 001001.
- Field forcing: shamt=0 except sll/srl; sll/srl force rs=0; jr forces rt=rd=0; jalr forces rt=0; lui forces rs=0.
- I-type {op,rs,rt,imm}: addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, slti 001010, bne 000101, andi 001100.
- J-type {op,target}: j 000010, jal 000011.
- in_ready = ~full. Accepted legal request is written into FIFO at that edge; out_valid rises next cycle (latency 1). No combinational path from in_* to out_*.
- Illegal mnemonic: request still consumed (in_ready rules unchanged), nothing enqueued, err set next cycle; err stays 1 until err_clr or rst.
- err_clr and illegal accept in same cycle: err = 1 (set wins).
- out_valid = ~empty; out_instr/out_addr valid whenever out_valid, held stable while out_valid&~out_ready.
- Address counter: starts BASE_ADDR; +4 on each output handshake; wraps modulo 2^32. out_addr reflects counter for current head.
- Full FIFO with simultaneous pop: in_ready stays 0 that cycle (ready depends only on full); no push-through.
- Empty FIFO with push: push takes effect, no bypass.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- flush: takes priority over push and pop in the same cycle; next cycle empty, address=BASE_ADDR; err unaffected.
- Reset (any time, including mid-stream): pointers/count 0, out_valid=0, in_ready=1 as soon as rst deasserts, out_instr=0, out_addr=BASE_ADDR, err=0. FIFO storage need not be cleared.
- Pointers wrap at DEPTH; full/empty decided by a count of width log2(DEPTH)+1.

Test Plan:
- addi rs=0 rt=8 imm=0x0005, out_ready=1 -> out_instr=0x20080005, out_addr=0x0, one cycle after accept.
- add rd=10 rs=8 rt=9 shamt=7, then sll rd=2 rt=1 shamt=4 rs=5 -> 0x01095020 (shamt forced 0) then 0x00011100 (rs forced 0), addrs 0x0, 0x4.
- lw rs=8 rt=9 imm=0x0004; j target=0x0000040 -> 0x8D090004, then 0x08000040.
- out_ready=0, push 5 words with DEPTH=4 -> in_ready low after 4th accept; release out_ready -> 4 words in order, 5th accepted only after a pop, addresses 0x0..0x10.
- mnem=27 accepted -> no output, err=1 next cycle; err_clr pulse -> err=0; simultaneous err_clr + illegal accept -> err=1.
- Fill 3 entries, assert rst mid-stream -> out_valid=0, in_ready=1, err=0 immediately; next word emits at BASE_ADDR. Repeat with flush -> same result, err unchanged.
